// File: rtl/clut_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clut_loader_pkg
// Purpose  : Shared GPU constants for the CLUT fetch path.
//            - FSM state encoding for the CLUT loader.
//            - VRAM geometry and burst sizes.
//            - CLUT_ID field layout: X in [5:0] (16-halfword units),
//              Y in [14:6] (row).
// Revision : 1.0 - initial release
// ============================================================================
package clut_loader_pkg;

    // VRAM geometry and burst shape
    localparam int CLUT_BEATS_PER_BLOCK = 8;
    localparam int CLUT_BLOCKS_8BPP     = 16;
    localparam int VRAM_WORD_AW         = 18;

    // CLUT_ID field layout
    localparam int CLUT_X_LSB = 0;
    localparam int CLUT_X_W   = 6;
    localparam int CLUT_Y_LSB = 6;
    localparam int CLUT_Y_W   = 9;

    // Loader FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage : clut_loader_pkg
`default_nettype wire

// File: rtl/clut_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : clut_addr_gen
// Purpose  : Combinational CLUT_ID + block number -> VRAM word address.
//            The X column advances by one 8-word block per block index and
//            wraps within the same row; Y is never incremented.
// Ports    : i_clutId   [14:0] CLUT identifier (X [5:0], Y [14:6])
//            i_blk      [3:0]  block offset from the CLUT start
//            o_wordAddr [17:0] VRAM word address, bits [2:0] always 0
// Revision : 1.0 - initial release
// ============================================================================
module clut_addr_gen
    import clut_loader_pkg::*;
(
    input  logic [14:0]             i_clutId,
    input  logic [3:0]              i_blk,
    output logic [VRAM_WORD_AW-1:0] o_wordAddr
);

    logic [CLUT_X_W-1:0] w_x;
    logic [CLUT_X_W-1:0] w_col;
    logic [CLUT_Y_W-1:0] w_y;

    assign w_x = i_clutId[CLUT_X_LSB +: CLUT_X_W];
    assign w_y = i_clutId[CLUT_Y_LSB +: CLUT_Y_W];

    // 6-bit sum: the carry is dropped so the column wraps inside the row
    assign w_col = w_x + {2'b00, i_blk};

    assign o_wordAddr = {w_y, w_col, 3'b000};

endmodule : clut_addr_gen
`default_nettype wire

// File: rtl/clut_loader.sv
`default_nettype none
// ============================================================================
// Module   : clut_loader
// Purpose  : Fills the GPU CLUT cache from VRAM on a cache miss. Issues one
//            8-word block read per 16 colors and streams each returned word
//            (two colors) into the cache write port, then pulses o_done.
// Macro    : CLUT_LOADER_8BPP_EN - when defined, i_is8bpp selects a 16-block
//            (256-color) load; when undefined every load is one block and
//            o_writeIdx128[6:3] is constant 0.
// Ports    : clk, i_rst (sync, active-high)
//            i_loadReq, i_clutId[14:0], i_is8bpp   - load request
//            o_memReq, o_memAddr[17:0], i_memAck    - block read request
//            i_dataValid, i_data[31:0]              - returned beats
//            o_write, o_writeIdx128[6:0], o_colorOut[31:0] - cache write
//            o_busy, o_done                         - status
// Revision : 1.0 - initial release
// ============================================================================
module clut_loader
    import clut_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    i_loadReq,
    input  logic [14:0]             i_clutId,
    input  logic                    i_is8bpp,
    output logic                    o_memReq,
    output logic [VRAM_WORD_AW-1:0] o_memAddr,
    input  logic                    i_memAck,
    input  logic                    i_dataValid,
    input  logic [31:0]             i_data,
    output logic                    o_write,
    output logic [6:0]              o_writeIdx128,
    output logic [31:0]             o_colorOut,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam logic [2:0] c_LAST_BEAT = 3'(CLUT_BEATS_PER_BLOCK - 1);

    logic [1:0]              r_state;
    logic [14:0]             r_clutId;
    logic [2:0]              r_beat;
    logic                    r_done;
    logic                    r_write;
    logic [6:0]              r_writeIdx;
    logic [31:0]             r_color;
    logic [3:0]              w_blk;
    logic [3:0]              w_lastBlk;
    logic                    w_accept;
    logic                    w_lastBeat;
    logic [VRAM_WORD_AW-1:0] w_blockAddr;

    // r_done covers the cycle after DONE, when the FSM is already back in
    // IDLE but the load still counts as busy; a held request waits it out.
    assign w_accept   = (r_state == ST_IDLE) && i_loadReq && !r_done;
    assign w_lastBeat = (r_state == ST_DATA) && i_dataValid && (r_beat == c_LAST_BEAT);

`ifdef CLUT_LOADER_8BPP_EN
    logic [3:0] r_blk;
    logic       r_is8bpp;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_blk    <= 4'd0;
            r_is8bpp <= 1'b0;
        end else if (w_accept) begin
            r_blk    <= 4'd0;
            r_is8bpp <= i_is8bpp;
        end else if (w_lastBeat && (r_blk != w_lastBlk)) begin
            r_blk <= r_blk + 4'd1;
        end
    end

    assign w_blk     = r_blk;
    assign w_lastBlk = r_is8bpp ? 4'(CLUT_BLOCKS_8BPP - 1) : 4'd0;
`else
    // Single-block build: the mode input has no effect, it is masked here
    // only so the port remains connected to logic.
    assign w_blk     = 4'd0;
    assign w_lastBlk = 4'd0 & {4{i_is8bpp}};
`endif

    clut_addr_gen u_addrGen (
        .i_clutId   (r_clutId),
        .i_blk      (w_blk),
        .o_wordAddr (w_blockAddr)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_clutId   <= 15'd0;
            r_beat     <= 3'd0;
            r_done     <= 1'b0;
            r_write    <= 1'b0;
            r_writeIdx <= 7'd0;
            r_color    <= 32'd0;
        end else begin
            r_write <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_clutId <= i_clutId;
                        r_beat   <= 3'd0;
                        r_state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_memAck) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (i_dataValid) begin
                        r_write    <= 1'b1;
                        r_writeIdx <= {w_blk, r_beat};
                        r_color    <= i_data;
                        // Wraps to 0 after the last beat, ready for the next block
                        r_beat     <= r_beat + 3'd1;
                        if (r_beat == c_LAST_BEAT) begin
                            r_state <= (w_blk == w_lastBlk) ? ST_DONE : ST_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_memReq      = (r_state == ST_REQ);
    assign o_memAddr     = o_memReq ? w_blockAddr : '0;
    assign o_write       = r_write;
    assign o_writeIdx128 = r_writeIdx;
    assign o_colorOut    = r_color;
    assign o_busy        = (r_state != ST_IDLE) || r_done;
    assign o_done        = r_done;

endmodule : clut_loader
`default_nettype wire

// File: doc/clut_loader.md
# clut_loader

Fetch engine that fills the GPU CLUT cache from VRAM. When the cache reports a CLUT miss, the block takes the 15-bit CLUT identifier and issues 8-word block reads to the VRAM memory arbiter. It streams each returned 32-bit word (two 16-bit colors) into the cache write port at the correct index, then signals completion so the texture path can resume lookups.

## Interface
- No parameters. Widths are fixed by the VRAM geometry: 1024×512 halfwords, 18-bit word address.
- `clk` in 1: sole clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_loadReq` in 1: level request, driven from the cache miss flag.
- `i_clutId` in 15: [5:0] X in 16-halfword units, [14:6] Y row.
- `i_is8bpp` in 1: 1 = load 256 colors (16 blocks); 0 = load 16 colors (1 block).
- `o_memReq` out 1: block read request, held until acknowledged.
- `o_memAddr` out 18: VRAM word address of the block. Bits [2:0] are always 0.
- `i_memAck` in 1: arbiter accepts the request this cycle.
- `i_dataValid` in 1: one data beat.
- `i_data` in 32: beat payload. Low halfword is the even color.
- `o_write` out 1: cache write strobe.
- `o_writeIdx128` out 7: cache word index.
- `o_colorOut` out 32: cache write data.
- `o_busy` out 1: a load is in progress.
- `o_done` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, REQ, DATA, DONE.
- IDLE:
  - When `i_loadReq`=1, latch `i_clutId` and `i_is8bpp`, clear the block counter `blk` (4 bits) and the beat counter `beat` (3 bits), then go to REQ.
- REQ:
  - `o_memReq`=1 with `o_memAddr` = {Y[8:0], (X+blk) mod 64, 3'b000}.
  - The X column wraps within the same row; Y never increments.
  - On `i_memAck`, go to DATA.
- DATA:
  - Each `i_dataValid` produces a registered cache write at index {blk, beat}, then increments `beat`.
  - On the 8th beat:
    - If this is the last block (4bpp: blk=0; 8bpp: blk=15), go to DONE.
    - Otherwise increment `blk` and go to REQ.
- DONE: go to IDLE. `o_done` is pulsed as specified under Timing.
- `i_dataValid` outside DATA is ignored. So is `i_memAck` outside REQ.
- `i_loadReq` is ignored while busy, including during DONE. A request still held one cycle after `o_done` starts a new load.
- Write indices:
  - 4bpp load writes indices 0..7 only.
  - 8bpp load writes 0..127 in ascending order.
- Reset values:
  - FSM in IDLE.
  - `o_memReq`, `o_write`, `o_busy`, `o_done` = 0.
  - `o_memAddr`, `o_writeIdx128`, `o_colorOut` = 0.
  - Counters = 0.
- Reset mid-load: abort immediately. No further writes or requests are issued. Partial cache contents are left untouched.

## Timing
- Request acceptance in cycle c: `o_busy`=1 and `o_memReq`=1 from cycle c+1.
- Ack handshake: `i_memAck` in cycle r drops `o_memReq` in r+1. The first beat is accepted no earlier than r+1.
- Write latency: a beat in cycle t gives `o_write`, `o_writeIdx128` and `o_colorOut` valid in t+1, for exactly one cycle per beat.
- Completion: with the final beat in cycle t, the last `o_write` occurs in t+1 and `o_done`=1 in t+2. `o_busy` is high from c+1 through t+2 inclusive, then 0.
- Next block: the REQ for block blk+1 is asserted the cycle after the 8th beat of block blk.
- Best-case latency with zero-wait ack and back-to-back beats:
  - 4bpp: 11 cycles, acceptance to `o_done`.
  - 8bpp: 16×9+2 = 146 cycles.

## Configuration
- `CLUT_LOADER_8BPP_EN` defined: full behaviour as above.
- `CLUT_LOADER_8BPP_EN` undefined:
  - `i_is8bpp` is ignored and every load is a single 4bpp block.
  - The `blk` counter is removed and tied to 0.
  - `o_writeIdx128[6:3]` is constant 0.

## Structure
- Shared GPU package holds:
  - FSM state encoding.
  - Constants `CLUT_BEATS_PER_BLOCK`=8, `CLUT_BLOCKS_8BPP`=16, `VRAM_WORD_AW`=18.
  - CLUT_ID field offsets (X [5:0], Y [14:6]).
- One sub-module, `clut_addr_gen`: combinational CLUT_ID+blk → word address with X wrap. It is reused by other VRAM fetchers.

## Test plan
- 4bpp, `i_clutId`={Y=5, X=3}, ack immediate, 8 back-to-back beats 0xA0000000+n:
  - `o_memAddr`=0x00A18.
  - Writes at idx 0..7 with matching data.
  - `o_done` exactly 11 cycles after acceptance.
- 8bpp, X=60, Y=511:
  - Block addresses have column field 60,61,62,63,0,1..11, all with Y=511.
  - Writes cover idx 0..127 in order.
  - Exactly one `o_done`.
- Wait-states:
  - Ack delayed 5 cycles: `o_memReq` held stable with constant address.
  - Gaps between beats: no spurious `o_write`.
  - Beats presented during REQ are ignored.
- `i_loadReq` held high throughout a load: no second request until the cycle after `o_done`, then a fresh load starts.
- `i_rst` asserted on the 3rd beat of block 2 of an 8bpp load:
  - Next cycle all outputs are 0 and the FSM is in IDLE.
  - No write occurs for the aborted beat.
- Macro undefined, `i_is8bpp`=1: single block, idx 0..7 only, `o_done` after 11 cycles.
